// File: rtl/mem2_wb_reg_if.sv
// -----------------------------------------------------------------------------
// mem2_wb_reg_if
// Purpose : Bundles the MEM2-side inputs and the WB-side registered outputs of
//           the MEM2/WB pipeline register into one interface.
// Params  : DW - data/address width, RW - register-file index width.
// Modports:
//   master - MEM2 stage / driver side: drives *_in and control, observes outputs.
//   slave  - pipeline register side: consumes *_in and control, drives outputs.
// Optional: MEM2WB_PERF_CNT_EN adds retired_cnt / load_cnt counter outputs.
// -----------------------------------------------------------------------------
interface mem2_wb_reg_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    // Stage control
    logic          freeze;
    logic          flush;

    // MEM2-stage inputs
    logic          WB_EN_in;
    logic          MEM_R_EN_in;
    logic [DW-1:0] ALU_result_in;
    logic [DW-1:0] dataMem_out_in;
    logic [RW-1:0] dest_in;
    logic [1:0]    load_size_in;
    logic          load_unsigned_in;

    // Registered WB-stage outputs
    logic          WB_EN;
    logic          MEM_R_EN;
    logic [DW-1:0] ALU_result;
    logic [DW-1:0] MEM_read_value;
    logic [RW-1:0] dest;
    logic          valid;
    logic          misalign_err;

`ifdef MEM2WB_PERF_CNT_EN
    logic [31:0]   retired_cnt;
    logic [31:0]   load_cnt;
`endif

    modport master (
        output freeze, flush,
        output WB_EN_in, MEM_R_EN_in, ALU_result_in, dataMem_out_in,
        output dest_in, load_size_in, load_unsigned_in,
        input  WB_EN, MEM_R_EN, ALU_result, MEM_read_value, dest, valid,
        input  misalign_err
`ifdef MEM2WB_PERF_CNT_EN
        ,
        input  retired_cnt, load_cnt
`endif
    );

    modport slave (
        input  freeze, flush,
        input  WB_EN_in, MEM_R_EN_in, ALU_result_in, dataMem_out_in,
        input  dest_in, load_size_in, load_unsigned_in,
        output WB_EN, MEM_R_EN, ALU_result, MEM_read_value, dest, valid,
        output misalign_err
`ifdef MEM2WB_PERF_CNT_EN
        ,
        output retired_cnt, load_cnt
`endif
    );

endinterface : mem2_wb_reg_if

// File: rtl/mem2_wb_reg.sv
// -----------------------------------------------------------------------------
// mem2_wb_reg
// Purpose : MEM2 -> WB pipeline register of the 6-stage MIPS pipeline.
//           Extracts the loaded byte/half/word (signed or unsigned, little-
//           endian lanes selected by the low address bits), flags misaligned
//           loads (sticky), and registers everything for write-back.
//           Supports freeze (hold) and flush (bubble), flush winning.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-low
//   bus  - mem2_wb_reg_if.slave: freeze/flush, MEM2 fields in, WB fields out
// Params  : DW (data/address width, lane logic assumes DW >= 32), RW (regidx).
// Optional: define MEM2WB_PERF_CNT_EN to add the retired_cnt / load_cnt
//           performance counters on the interface.
// -----------------------------------------------------------------------------
module mem2_wb_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    mem2_wb_reg_if.slave  bus
);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // -------------------------------------------------------------------------
    // Load-data extraction: picks the lane addressed by off and extends it.
    // Word and the reserved size code both pass the raw word through.
    // -------------------------------------------------------------------------
    function automatic logic [DW-1:0] extract_load(
        input logic [DW-1:0] word,
        input logic [1:0]    size,
        input logic          uns,
        input logic [1:0]    off
    );
        logic [7:0]    lane_b;
        logic [15:0]   lane_h;
        logic [DW-1:0] res;
        lane_b = 8'h00;
        lane_h = 16'h0000;
        res    = word;
        case (off)
            2'b00:   lane_b = word[7:0];
            2'b01:   lane_b = word[15:8];
            2'b10:   lane_b = word[23:16];
            2'b11:   lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        // Half lane uses only off[1]; a misaligned half still reads its
        // enclosing aligned halfword.
        if (off[1]) begin
            lane_h = word[31:16];
        end else begin
            lane_h = word[15:0];
        end
        case (size)
            SZ_BYTE: begin
                if (uns) begin
                    res = {{(DW-8){1'b0}}, lane_b};
                end else begin
                    res = {{(DW-8){lane_b[7]}}, lane_b};
                end
            end
            SZ_HALF: begin
                if (uns) begin
                    res = {{(DW-16){1'b0}}, lane_h};
                end else begin
                    res = {{(DW-16){lane_h[15]}}, lane_h};
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Misalignment: half at an odd address, or word (incl. reserved size) at
    // any non-zero offset. Bytes are never misaligned. Only loads count.
    // -------------------------------------------------------------------------
    function automatic logic is_misaligned(
        input logic       is_load,
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic m;
        m = 1'b0;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = off[0];
            default: m = (off != 2'b00);
        endcase
        return is_load & m;
    endfunction

    // Registered state
    logic          wb_en_q,    wb_en_d;
    logic          mem_r_en_q, mem_r_en_d;
    logic [DW-1:0] alu_q,      alu_d;
    logic [DW-1:0] rdval_q,    rdval_d;
    logic [RW-1:0] dest_q,     dest_d;
    logic          valid_q,    valid_d;
    logic          mis_err_q,  mis_err_d;

    // Combinational helpers
    logic [1:0]    off_s;
    logic          mis_s;
    logic [DW-1:0] ext_s;

    // Decode offset, extracted data and misalignment from the MEM2 inputs.
    always_comb begin
        off_s = bus.ALU_result_in[1:0];
        ext_s = extract_load(bus.dataMem_out_in, bus.load_size_in,
                             bus.load_unsigned_in, off_s);
        mis_s = is_misaligned(bus.MEM_R_EN_in, bus.load_size_in, off_s);
    end

    // Next-state selection: flush beats freeze; freeze holds everything.
    always_comb begin
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        alu_d      = alu_q;
        rdval_d    = rdval_q;
        dest_d     = dest_q;
        valid_d    = valid_q;
        mis_err_d  = mis_err_q;
        if (bus.flush) begin
            // Bubble: clear the slot but keep the sticky error as is.
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
            alu_d      = {DW{1'b0}};
            rdval_d    = {DW{1'b0}};
            dest_d     = {RW{1'b0}};
            valid_d    = 1'b0;
        end else if (bus.freeze) begin
            wb_en_d    = wb_en_q;
            valid_d    = valid_q;
        end else begin
            // A misaligned load must not write the register file.
            wb_en_d    = bus.WB_EN_in & ~mis_s;
            mem_r_en_d = bus.MEM_R_EN_in;
            alu_d      = bus.ALU_result_in;
            rdval_d    = ext_s;
            dest_d     = bus.dest_in;
            valid_d    = 1'b1;
            mis_err_d  = mis_err_q | mis_s;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_q      <= {DW{1'b0}};
            rdval_q    <= {DW{1'b0}};
            dest_q     <= {RW{1'b0}};
            valid_q    <= 1'b0;
            mis_err_q  <= 1'b0;
        end else begin
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_q      <= alu_d;
            rdval_q    <= rdval_d;
            dest_q     <= dest_d;
            valid_q    <= valid_d;
            mis_err_q  <= mis_err_d;
        end
    end

    assign bus.WB_EN          = wb_en_q;
    assign bus.MEM_R_EN       = mem_r_en_q;
    assign bus.ALU_result     = alu_q;
    assign bus.MEM_read_value = rdval_q;
    assign bus.dest           = dest_q;
    assign bus.valid          = valid_q;
    assign bus.misalign_err   = mis_err_q;

`ifdef MEM2WB_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] load_q,    load_d;

    // Counters advance only on normal-load edges; wrap naturally at 2^32.
    always_comb begin
        retired_d = retired_q;
        load_d    = load_q;
        if (!bus.flush && !bus.freeze) begin
            if (bus.WB_EN_in) begin
                retired_d = retired_q + 32'd1;
            end else begin
                retired_d = retired_q;
            end
            if (bus.MEM_R_EN_in && !mis_s) begin
                load_d = load_q + 32'd1;
            end else begin
                load_d = load_q;
            end
        end else begin
            retired_d = retired_q;
            load_d    = load_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_q <= 32'd0;
            load_q    <= 32'd0;
        end else begin
            retired_q <= retired_d;
            load_q    <= load_d;
        end
    end

    assign bus.retired_cnt = retired_q;
    assign bus.load_cnt    = load_q;
`else
`endif

endmodule : mem2_wb_reg

// File: tb/tb_mem2_wb_reg.sv
// -----------------------------------------------------------------------------
// tb_mem2_wb_reg
// Directed-vector bench for mem2_wb_reg. Inputs are driven after each rising
// edge; outputs are sampled 1 time unit after the edge that registers them.
// -----------------------------------------------------------------------------
module tb_mem2_wb_reg;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   miscompare_cnt;

    mem2_wb_reg_if #(.DW(32), .RW(5)) bus ();

    mem2_wb_reg #(.DW(32), .RW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wb, input logic mre,
                          input logic [31:0] alu, input logic [31:0] data,
                          input logic [4:0] dst, input logic [1:0] size,
                          input logic uns);
        bus.WB_EN_in         = wb;
        bus.MEM_R_EN_in      = mre;
        bus.ALU_result_in    = alu;
        bus.dataMem_out_in   = data;
        bus.dest_in          = dst;
        bus.load_size_in     = size;
        bus.load_unsigned_in = uns;
    endtask

    task automatic check_cleared(input string tag);
        check_vec({tag, ".WB_EN"},    {31'd0, bus.WB_EN},        32'd0);
        check_vec({tag, ".MEM_R_EN"}, {31'd0, bus.MEM_R_EN},     32'd0);
        check_vec({tag, ".ALU"},      bus.ALU_result,            32'd0);
        check_vec({tag, ".RDVAL"},    bus.MEM_read_value,        32'd0);
        check_vec({tag, ".dest"},     {27'd0, bus.dest},         32'd0);
        check_vec({tag, ".valid"},    {31'd0, bus.valid},        32'd0);
        check_vec({tag, ".mis"},      {31'd0, bus.misalign_err}, 32'd0);
    endtask

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        rst        = 1'b0;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;

        // ---- Reset with random inputs for two edges ----
        for (int i = 0; i < 2; i++) begin
            set_in(1'($urandom), 1'($urandom), $urandom, $urandom,
                   5'($urandom), 2'($urandom), 1'($urandom));
            bus.freeze = 1'($urandom);
            bus.flush  = 1'($urandom);
            tick();
        end
        check_cleared("reset");
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        rst = 1'b1;

        // ---- First normal load ----
        set_in(1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5, 2'b00, 1'b0);
        tick();
        check_vec("first.WB_EN", {31'd0, bus.WB_EN},  32'd1);
        check_vec("first.dest",  {27'd0, bus.dest},   32'd5);
        check_vec("first.valid", {31'd0, bus.valid},  32'd1);
        check_vec("first.ALU",   bus.ALU_result,      32'h10);
        check_vec("first.MRE",   {31'd0, bus.MEM_R_EN}, 32'd0);

        // ---- Byte extraction ----
        set_in(1'b1, 1'b1, 32'h0000_0001, 32'h80FF_7F01, 5'd3, 2'b10, 1'b0);
        tick();
        check_vec("byte.off1.s", bus.MEM_read_value, 32'h0000_007F);
        check_vec("byte.off1.MRE", {31'd0, bus.MEM_R_EN}, 32'd1);
        set_in(1'b1, 1'b1, 32'h0000_0002, 32'h80FF_7F01, 5'd3, 2'b10, 1'b0);
        tick();
        check_vec("byte.off2.s", bus.MEM_read_value, 32'hFFFF_FFFF);
        set_in(1'b1, 1'b1, 32'h0000_0003, 32'h80FF_7F01, 5'd3, 2'b10, 1'b1);
        tick();
        check_vec("byte.off3.u", bus.MEM_read_value, 32'h0000_0080);
        check_vec("byte.noMis.WB", {31'd0, bus.WB_EN}, 32'd1);
        set_in(1'b1, 1'b1, 32'h0000_0000, 32'h80FF_7F01, 5'd3, 2'b10, 1'b0);
        tick();
        check_vec("byte.off0.s", bus.MEM_read_value, 32'h0000_0001);

        // ---- Half extraction ----
        set_in(1'b1, 1'b1, 32'h0000_0002, 32'h8001_ABCD, 5'd4, 2'b01, 1'b0);
        tick();
        check_vec("half.off2.s", bus.MEM_read_value, 32'hFFFF_8001);
        set_in(1'b1, 1'b1, 32'h0000_0000, 32'h8001_ABCD, 5'd4, 2'b01, 1'b1);
        tick();
        check_vec("half.off0.u", bus.MEM_read_value, 32'h0000_ABCD);
        set_in(1'b1, 1'b1, 32'h0000_0000, 32'h8001_ABCD, 5'd4, 2'b01, 1'b0);
        tick();
        check_vec("half.off0.s", bus.MEM_read_value, 32'hFFFF_ABCD);

        // ---- Reserved size passes the word; non-load misaligned is benign ----
        set_in(1'b1, 1'b0, 32'h0000_0103, 32'h1234_5678, 5'd6, 2'b11, 1'b0);
        tick();
        check_vec("rsvd.pass", bus.MEM_read_value, 32'h1234_5678);
        check_vec("nonload.WB", {31'd0, bus.WB_EN}, 32'd1);
        check_vec("nonload.mis", {31'd0, bus.misalign_err}, 32'd0);

        // ---- Misaligned word load ----
        set_in(1'b1, 1'b1, 32'h0000_0102, 32'hCAFE_F00D, 5'd9, 2'b00, 1'b0);
        tick();
        check_vec("mis.err",   {31'd0, bus.misalign_err}, 32'd1);
        check_vec("mis.WB",    {31'd0, bus.WB_EN},        32'd0);
        check_vec("mis.valid", {31'd0, bus.valid},        32'd1);
        check_vec("mis.data",  bus.MEM_read_value,        32'hCAFE_F00D);

        // Three clean loads: error stays set
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 32'h0000_0200 + 32'(4 * i), 32'h0000_0011 + 32'(i),
                   5'd10, 2'b00, 1'b0);
            tick();
            check_vec("mis.sticky", {31'd0, bus.misalign_err}, 32'd1);
        end
        check_vec("clean.WB",   {31'd0, bus.WB_EN}, 32'd1);
        check_vec("clean.data", bus.MEM_read_value, 32'h0000_0013);

        // Misaligned half (off=3): data still from upper half, WB blocked
        set_in(1'b1, 1'b1, 32'h0000_0003, 32'h8001_ABCD, 5'd11, 2'b01, 1'b0);
        tick();
        check_vec("mishalf.data", bus.MEM_read_value, 32'hFFFF_8001);
        check_vec("mishalf.WB",   {31'd0, bus.WB_EN}, 32'd0);

        // ---- Freeze: capture dest=7 then hold for 3 edges ----
        set_in(1'b1, 1'b0, 32'h0000_0777, 32'h0, 5'd7, 2'b00, 1'b0);
        tick();
        check_vec("cap.dest", {27'd0, bus.dest}, 32'd7);
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 32'h0000_0F01 + 32'(i), 32'hDEAD_0000, 5'(20 + i),
                   2'b00, 1'b0);
            tick();
            check_vec("frz.dest", {27'd0, bus.dest},  32'd7);
            check_vec("frz.ALU",  bus.ALU_result,     32'h0000_0777);
            check_vec("frz.WB",   {31'd0, bus.WB_EN}, 32'd1);
            check_vec("frz.mis",  {31'd0, bus.misalign_err}, 32'd1);
        end

        // ---- Freeze + flush: flush wins, sticky error kept ----
        bus.flush = 1'b1;
        tick();
        check_vec("fl.valid", {31'd0, bus.valid},  32'd0);
        check_vec("fl.WB",    {31'd0, bus.WB_EN},  32'd0);
        check_vec("fl.dest",  {27'd0, bus.dest},   32'd0);
        check_vec("fl.ALU",   bus.ALU_result,      32'd0);
        check_vec("fl.mis",   {31'd0, bus.misalign_err}, 32'd1);
        bus.flush = 1'b0;

        // Freeze after a bubble keeps valid=0
        tick();
        check_vec("frzbub.valid", {31'd0, bus.valid}, 32'd0);

        // ---- Reset mid-stall clears everything ----
        rst = 1'b0;
        tick();
        check_cleared("rststall");
        rst = 1'b1;
        bus.freeze = 1'b0;

`ifdef MEM2WB_PERF_CNT_EN
        check_vec("perf.rst.ret",  bus.retired_cnt, 32'd0);
        check_vec("perf.rst.load", bus.load_cnt,    32'd0);
        // 4 aligned word loads
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 32'(16 * i), 32'h0, 5'd1, 2'b00, 1'b0);
            tick();
        end
        // 2 ALU ops
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 32'h0000_0005, 32'h0, 5'd2, 2'b00, 1'b0);
            tick();
        end
        // 1 flushed load, then 2 frozen load edges
        set_in(1'b1, 1'b1, 32'h0, 32'h0, 5'd3, 2'b00, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush  = 1'b0;
        bus.freeze = 1'b1;
        tick();
        tick();
        bus.freeze = 1'b0;
        check_vec("perf.ret",  bus.retired_cnt, 32'd6);
        check_vec("perf.load", bus.load_cnt,    32'd4);
        // Misaligned load retires-count but is not a good load
        set_in(1'b1, 1'b1, 32'h0000_0001, 32'h0, 5'd3, 2'b00, 1'b0);
        tick();
        check_vec("perf.misret",  bus.retired_cnt, 32'd7);
        check_vec("perf.misload", bus.load_cnt,    32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule : tb_mem2_wb_reg

// File: doc/mem2_wb_reg.md
Name: mem2_wb_reg

Overview:
- Pipeline register between the second memory stage and write-back in the 6-stage MIPS pipeline.
- Consumes the data-memory read word and the forwarded ALU/control fields of the MEM2 stage.
- Performs load-size extraction (byte/half/word, signed/unsigned), detects misaligned loads, and registers the result for WB.
- Supports freeze (stall hold) and flush (bubble insertion).

Parameters:
- DW, 32, data/address width
- RW, 5, register-file index width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-low; asserted when 0, sampled on rising clk
- freeze  input  1  hold all registered outputs this cycle
- flush  input  1  load a bubble this cycle; overrides freeze
- WB_EN_in  input  1  write-back enable from MEM2
- MEM_R_EN_in  input  1  instruction is a load
- ALU_result_in  input  DW  effective address / ALU result
- dataMem_out_in  input  DW  raw word read from data memory
- dest_in  input  RW  destination register index
- load_size_in  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend
- WB_EN  output  1  registered write-back enable
- MEM_R_EN  output  1  registered load flag (WB mux select)
- ALU_result  output  DW  registered ALU result
- MEM_read_value  output  DW  registered extracted load data
- dest  output  RW  registered destination index
- valid  output  1  registered slot holds a real instruction
- misalign_err  output  1  sticky misaligned-load flag

Behaviour:
- Reset (rst==0 at a rising edge): all outputs 0, including misalign_err. Reset overrides flush and freeze.
- Latency: inputs sampled on the rising edge, visible the same edge; one-cycle register stage.
- Priority per edge: reset > flush > freeze > normal load.
- Normal load:
  - Capture all fields.
  - valid <= 1.
  - MEM_R_EN <= MEM_R_EN_in.
  - WB_EN <= WB_EN_in & ~mis, where mis is defined below.
- Flush: valid, WB_EN and MEM_R_EN <= 0. ALU_result, MEM_read_value and dest <= 0. misalign_err is unchanged.
- Freeze (without flush): every output, including valid, holds its previous value. No misalign update.
- Extraction uses off = ALU_result_in[1:0] and little-endian byte lanes.
  - Byte: lane = dataMem_out_in[8*off+7 : 8*off]. Extend to DW by sign (bit 7) or zero.
  - Half: lane = dataMem_out_in[16*off[1]+15 : 16*off[1]]. Extend by sign (bit 15) or zero.
  - Word / reserved size: pass through unchanged.
- Misalignment, mis = MEM_R_EN_in & ((half & off[0]) | (word & off!=0)).
  - Computed only on normal-load cycles.
  - On mis: misalign_err <= 1 (sticky until reset) and WB_EN forced 0. Data is still extracted as defined above, using off[1] for half and no shift for word.
- When MEM_R_EN_in == 0, extraction still runs on dataMem_out_in. MEM_read_value is don't-care for WB, but its value must follow the rules above deterministically.
- Simultaneous flush and freeze: the flush is applied.
- Reset asserted mid-stall: all outputs clear; freeze is ignored on that edge.

Optional Feature:
- Macro: MEM2WB_PERF_CNT_EN.
- When defined, add two outputs:
  - retired_cnt [31:0]: increments on each normal-load edge with WB_EN_in==1.
  - load_cnt [31:0]: increments on each normal-load edge with MEM_R_EN_in==1 and no misalignment.
- Counter rules: both reset to 0, wrap modulo 2^32, hold on freeze, and do not increment on flush.
- When not defined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset: drive rst=0 for 2 edges with random inputs -> all outputs 0, misalign_err=0. Release rst, then load WB_EN_in=1, dest_in=5, ALU_result_in=0x10 -> WB_EN=1, dest=5, valid=1, ALU_result=0x10.
- Byte extraction: dataMem_out_in=0x80FF7F01, byte, off=1, signed -> MEM_read_value=0x0000007F. Same input with off=2 -> 0xFFFFFFFF. Same input with off=3, unsigned -> 0x00000080.
- Half extraction: dataMem_out_in=0x8001ABCD, half, off=2, signed -> 0xFFFF8001. off=0, unsigned -> 0x0000ABCD.
- Misaligned load: word load, addr 0x102, WB_EN_in=1 -> misalign_err=1, WB_EN=0, valid=1. misalign_err stays 1 after 3 further clean loads; it clears only on rst=0.
- Freeze/flush: capture dest=7, then freeze=1 for 3 edges with changing inputs -> outputs stay at dest=7. Drive freeze=1 and flush=1 together -> valid=0, WB_EN=0, dest=0.
- MEM2WB_PERF_CNT_EN build: apply 4 loads and 2 ALU ops (all WB_EN_in=1), 1 flushed op and 2 freeze edges -> retired_cnt=6, load_cnt=4. Preset the counters near wrap by running 2^32 increments in a fast-forced sim -> both wrap to 0.
